addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Round-robin controller sharing one 32-bit add_sub datapath instance between two requesters (req0, req1).
- Registers the winning operands, drives the shared unit for one execute cycle, then returns result plus correct carry/overflow flags on a tagged response port.
- Flags are computed here from operands and adder result. The shared unit's own flag outputs are ignored.

Parameters:
WIDTH, 32, operand/result width; all arithmetic rules below are stated for WIDTH=32 and scale with it.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_sub  input  1  0=add, 1=subtract (A-B)
req0_unsigned  input  1  0=signed, 1=unsigned
req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_unsigned  same as req0 for requester 1
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_id  output  1  requester index owning the response
resp_data  output  WIDTH  result
resp_carry  output  1  raw carry out of MSB
resp_overflow  output  1  signed overflow or unsigned out-of-range
au_value1  output  WIDTH  to shared unit value1
au_value2  output  WIDTH  to shared unit value2
au_control  output  1  to shared unit control (1=sub)
au_signedness  output  1  to shared unit signedness (1=unsigned)
au_en  output  1  to shared unit EN
au_value_out  input  WIDTH  from shared unit value_out, combinational

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; operand regs, resp regs 0; last_grant=1 (req0 wins first). An in-flight operation is discarded and no response is produced.
- Arbitration (combinational each cycle): if exactly one valid, that one wins. If both valid, the requester != last_grant wins. last_grant updates only on an accepted handshake.
- reqX_ready is asserted only to the winner, and only in an accepting condition (below). Requesters hold operands stable while valid=1 and ready=0.
- FSM:
  - IDLE: the winner gets ready=1. On handshake, latch a, b, sub, unsigned and id into the operand regs; go to EXEC.
  - EXEC: au_en=1. Capture au_value_out, computed flags and id into the resp regs; go to RESP.
  - RESP: resp_valid=1.
    - resp_ready=0: hold; no req_ready.
    - resp_ready=1 with a winner: the winner gets ready=1 in the same cycle; latch its operands; go to EXEC.
    - resp_ready=1 with no winner: go to IDLE.
- au_value1/au_value2/au_control/au_signedness are driven continuously from the operand regs. au_en=1 only in EXEC.
- Latency: handshake at edge N; EXEC during cycle N+1; resp_valid=1 from cycle N+2.
- Throughput: 1 op per 2 cycles under continuous demand and resp_ready=1.
- Flags, with b' = b XOR {WIDTH{sub}}, s = au_value_out:
  - carry = majority(a[MSB], b'[MSB], a[MSB]^b'[MSB]^s[MSB]), i.e. the carry out of a + b' + sub.
  - Signed (unsigned=0): overflow = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]).
  - Unsigned (unsigned=1): overflow = carry XOR sub (add carry-out, or subtract borrow).
- Result wraps modulo 2^WIDTH.
- resp_* hold stable while resp_valid=1 and resp_ready=0.
- reqX_valid dropping before ready has no effect. A request withdrawn in the same cycle as a grant is not latched, because ready and valid must both be 1.

Test Plan:
- Signed add, req0: a=0x7FFFFFFF, b=0x00000001, sub=0, unsigned=0 -> resp_data=0x80000000, overflow=1, carry=0, resp_id=0, resp_valid exactly 2 cycles after accept.
- Unsigned sub, req1 only: a=0, b=1 -> resp_data=0xFFFFFFFF, carry=0, overflow=1. Then a=5, b=3 -> resp_data=0x00000002, carry=1, overflow=0.
- Unsigned add: a=0xFFFFFFFF, b=1 -> resp_data=0, carry=1, overflow=1. Signed -1+1 gives the same data and carry=1, with overflow=0.
- Contention: both valid continuously, resp_ready=1 -> accepted ids 0,1,0,1,... and one accept every 2 cycles. au_en high on alternate cycles only.
- Backpressure: resp_ready=0 for 5 cycles with both valid -> resp_* stable, no req_ready, au_en=0. Releasing resp_ready accepts the next winner in the same cycle.
- Reset during EXEC: rst_n=0 mid-cycle -> all outputs 0 immediately, no response after release, first grant goes to req0.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one add/sub unit between two requesters
// and returns the result with locally computed carry/overflow flags.
//
// state | meaning
// IDLE  | no operation in flight; the arbitration winner is offered ready
// EXEC  | shared unit enabled; result and flags captured at the end of the cycle
// RESP  | response presented; a new winner may be accepted when it is consumed
module addsub_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req0_unsigned,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    input  logic             req1_unsigned,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_overflow,

    output logic [WIDTH-1:0] au_value1,
    output logic [WIDTH-1:0] au_value2,
    output logic             au_control,
    output logic             au_signedness,
    output logic             au_en,
    input  logic [WIDTH-1:0] au_value_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             op_unsigned;
    logic             op_id;

    logic             any_valid;
    logic             win_id;
    logic             accepting;
    logic             grant;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_sub;
    logic             win_unsigned;

    assign any_valid = req0_valid | req1_valid;
    // With both requesting, the side that did not win last time goes next.
    assign win_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    // Gating with rst_n keeps ready low for the whole reset window.
    assign accepting = rst_n & ((state == IDLE) | ((state == RESP) & resp_ready));
    assign grant     = accepting & any_valid;

    assign req0_ready = grant & ~win_id;
    assign req1_ready = grant & win_id;

    assign win_a        = win_id ? req1_a        : req0_a;
    assign win_b        = win_id ? req1_b        : req0_b;
    assign win_sub      = win_id ? req1_sub      : req0_sub;
    assign win_unsigned = win_id ? req1_unsigned : req0_unsigned;

    assign au_value1     = op_a;
    assign au_value2     = op_b;
    assign au_control    = op_sub;
    assign au_signedness = op_unsigned;

    // Flags are rebuilt from the MSBs of a, the effective b and the sum, so
    // the shared unit's own flag outputs are not needed.
    logic [WIDTH-1:0] b_eff;
    logic             a_msb;
    logic             b_msb;
    logic             s_msb;
    logic             carry_in_msb;
    logic             flag_carry;
    logic             flag_overflow;

    assign b_eff        = op_b ^ {WIDTH{op_sub}};
    assign a_msb        = op_a[WIDTH-1];
    assign b_msb        = b_eff[WIDTH-1];
    assign s_msb        = au_value_out[WIDTH-1];
    assign carry_in_msb = a_msb ^ b_msb ^ s_msb;
    assign flag_carry   = (a_msb & b_msb) | (a_msb & carry_in_msb) | (b_msb & carry_in_msb);

    always_comb begin
        flag_overflow = 1'b0;
        if (op_unsigned) begin
            flag_overflow = flag_carry ^ op_sub;
        end else begin
            flag_overflow = (a_msb == b_msb) && (s_msb != a_msb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_a          <= '0;
            op_b          <= '0;
            op_sub        <= 1'b0;
            op_unsigned   <= 1'b0;
            op_id         <= 1'b0;
            au_en         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_data     <= '0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
        end else begin
            // A grant is only possible in IDLE or in a consumed RESP, and in
            // both cases the next state is EXEC.
            au_en <= grant;
            if (grant) begin
                op_a        <= win_a;
                op_b        <= win_b;
                op_sub      <= win_sub;
                op_unsigned <= win_unsigned;
                op_id       <= win_id;
                last_grant  <= win_id;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data     <= au_value_out;
                    resp_carry    <= flag_carry;
                    resp_overflow <= flag_overflow;
                    resp_id       <= op_id;
                    resp_valid    <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= grant ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed operations with hand-computed
// results, a behavioural shared adder, and decoupled accept/response monitors.
module tb_addsub_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req0_ready, req0_sub, req0_unsigned;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub, req1_unsigned;
    logic [W-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_carry, resp_overflow;
    logic [W-1:0] resp_data;
    logic [W-1:0] au_value1, au_value2, au_value_out;
    logic         au_control, au_signedness, au_en;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub), .req0_unsigned(req0_unsigned),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub), .req1_unsigned(req1_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_carry(resp_carry), .resp_overflow(resp_overflow),
        .au_value1(au_value1), .au_value2(au_value2), .au_control(au_control),
        .au_signedness(au_signedness), .au_en(au_en), .au_value_out(au_value_out)
    );

    // Shared unit: plain modular add/sub.
    assign au_value_out = au_control ? (au_value1 - au_value2) : (au_value1 + au_value2);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub, uns;
        logic [W-1:0] d;
        logic         c, o;
    } vec_t;

    typedef struct {
        logic         id;
        logic [W-1:0] d;
        logic         c, o;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   acc_id_log[$];
    int   acc_cyc_log[$];
    bit   aen_hist [0:8191];
    vec_t cur0, cur1;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                input logic uns, input logic [W-1:0] d, input logic c, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.uns = uns; v.d = d; v.c = c; v.o = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic set_req(input int id, input vec_t v, input logic valid);
        if (id == 0) begin
            cur0 = v; req0_a = v.a; req0_b = v.b; req0_sub = v.sub; req0_unsigned = v.uns;
            req0_valid = valid;
        end else begin
            cur1 = v; req1_a = v.a; req1_b = v.b; req1_sub = v.sub; req1_unsigned = v.uns;
            req1_valid = valid;
        end
    endtask

    // Present one operation and hold it until accepted; called at posedge+1.
    task automatic drv(input int id, input vec_t v, input bit last);
        bit hs = 1'b0;
        int n = 0;
        set_req(id, v, 1'b1);
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = (id == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            n++;
        end
        if (!hs) fail($sformatf("req%0d_accept", id));
        #1;
        if (last) begin
            if (id == 0) req0_valid = 1'b0;
            else         req1_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_req0_ready"}, req0_ready, 0);
        chk({name, "_req1_ready"}, req1_ready, 0);
        chk({name, "_resp_valid"}, resp_valid, 0);
        chk({name, "_resp_id"}, resp_id, 0);
        chk({name, "_resp_data"}, resp_data, 0);
        chk({name, "_resp_flags"}, {resp_carry, resp_overflow}, 0);
        chk({name, "_au_values"}, {au_value1, au_value2}, 0);
        chk({name, "_au_ctrl"}, {au_control, au_signedness, au_en}, 0);
    endtask

    // Accept monitor: a handshake seen at a falling edge completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        aen_hist[cyc % 8192] = au_en;
        if (req0_valid && req0_ready) begin
            e.id = 1'b0; e.d = cur0.d; e.c = cur0.c; e.o = cur0.o; e.acc = cyc;
            sb.push_back(e); acc_id_log.push_back(0); acc_cyc_log.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
            e.id = 1'b1; e.d = cur1.d; e.c = cur1.c; e.o = cur1.o; e.acc = cyc;
            sb.push_back(e); acc_id_log.push_back(1); acc_cyc_log.push_back(cyc);
        end
    end

    // Response monitor.
    bit seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_response", resp_data, 0);
                n_fail += (resp_data == 0) ? 1 : 0;
                if (resp_data == 0) $display("FAIL unexpected_response: got resp_valid=1, expected no response");
            end else begin
                e = sb[0];
                if (!seen) begin
                    chk("resp_latency", cyc, e.acc + 2);
                    seen = 1'b1;
                end
                if (resp_ready) begin
                    chk("resp_id", resp_id, e.id);
                    chk("resp_data", resp_data, e.d);
                    chk("resp_carry", resp_carry, e.c);
                    chk("resp_overflow", resp_overflow, e.o);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [W-1:0] hold_d;
        logic         hold_id, hold_c, hold_o;
        int           n;
        int           first;
        vec_t         zero_v;

        zero_v = mk(0, 0, 0, 0, 0, 0, 0);
        set_req(0, zero_v, 1'b0);
        set_req(1, zero_v, 1'b0);
        resp_ready = 1'b0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;

        // Signed and unsigned corner cases, one requester at a time.
        drv(0, mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1), 1);
        drain("drain_sadd_ovf");
        drv(1, mk(32'h0000_0000, 32'h0000_0001, 1, 1, 32'hFFFF_FFFF, 0, 1), 1);
        drv(1, mk(32'h0000_0005, 32'h0000_0003, 1, 1, 32'h0000_0002, 1, 0), 1);
        drv(0, mk(32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1), 1);
        drv(0, mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 32'h0000_0000, 1, 1), 1);
        drv(1, mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0), 1);
        drain("drain_corners");

        // Contention: both valid continuously, last grant was req1.
        acc_id_log.delete();
        acc_cyc_log.delete();
        fork
            begin
                drv(0, mk(32'h0000_0001, 32'h0000_0002, 0, 0, 32'h0000_0003, 0, 0), 0);
                drv(0, mk(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1), 0);
                drv(0, mk(32'h0000_000A, 32'h0000_0014, 1, 1, 32'hFFFF_FFF6, 0, 1), 1);
            end
            begin
                drv(1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h0000_0000, 1, 0), 0);
                drv(1, mk(32'h4000_0000, 32'h4000_0000, 0, 0, 32'h8000_0000, 0, 1), 0);
                drv(1, mk(32'h0000_0064, 32'hFFFF_FF9C, 0, 1, 32'h0000_0000, 1, 1), 1);
            end
        join
        drain("drain_contention");
        chk("contention_accepts", acc_id_log.size(), 6);
        if (acc_id_log.size() == 6) begin
            first = acc_cyc_log[0];
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("contention_id%0d", i), acc_id_log[i], i % 2);
                chk($sformatf("contention_cyc%0d", i), acc_cyc_log[i], first + 2 * i);
            end
            for (int c = first + 1; c <= acc_cyc_log[5] + 1; c++)
                chk($sformatf("contention_au_en_c%0d", c - first), aen_hist[c % 8192], (c - first) % 2);
        end

        // Backpressure: response held for 5 cycles with both requesters waiting.
        resp_ready = 1'b0;
        fork
            drv(0, mk(32'h1234_5678, 32'h1234_5678, 1, 0, 32'h0000_0000, 1, 0), 1);
            drv(1, mk(32'hFFFF_FFFE, 32'h0000_0003, 0, 1, 32'h0000_0001, 1, 1), 1);
            begin
                n = 0;
                @(negedge clk);
                while (!resp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!resp_valid) fail("bp_resp_valid");
                hold_d = resp_data; hold_id = resp_id; hold_c = resp_carry; hold_o = resp_overflow;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_resp_valid_held", resp_valid, 1);
                    chk("bp_resp_stable", {resp_id, resp_data, resp_carry, resp_overflow},
                        {hold_id, hold_d, hold_c, hold_o});
                    chk("bp_no_ready", {req0_ready, req1_ready}, 0);
                    chk("bp_au_en", au_en, 0);
                end
                @(posedge clk); #1;
                resp_ready = 1'b1;
                #1;
                chk("bp_release_req1_ready", req1_ready, 1);
            end
        join
        drain("drain_backpressure");

        // Reset while an operation from req0 is executing.
        drv(0, mk(32'h0000_0001, 32'h0000_0001, 0, 0, 32'h0000_0002, 0, 0), 1);
        @(negedge clk);
        chk("rst_exec_au_en", au_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_exec");
        sb.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready_gated", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_no_resp", resp_valid, 0);
            chk("rst_no_au_en", au_en, 0);
        end
        @(posedge clk); #1;
        acc_id_log.delete();
        acc_cyc_log.delete();
        fork
            drv(0, mk(32'h0000_0010, 32'h0000_0020, 1, 0, 32'hFFFF_FFF0, 0, 0), 1);
            drv(1, mk(32'h0000_0003, 32'h0000_0004, 0, 1, 32'h0000_0007, 0, 0), 1);
        join
        drain("drain_after_reset");
        chk("rst_accepts", acc_id_log.size(), 2);
        if (acc_id_log.size() == 2) begin
            chk("rst_first_grant", acc_id_log[0], 0);
            chk("rst_second_grant", acc_id_log[1], 1);
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
